// File: rtl/uart_tx_cfg_if.sv
// Byte-side handshake and serial-line status bundle for uart_tx_cfg.
// The producer uses the master view and the transmitter uses the slave view.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx_out;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx_out, tx_busy, tx_done
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx_out, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// Every output is registered; tx_out is computed one cycle ahead from the next state.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_cfg_if.slave bus
);
    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY_EN and PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_reg,  state_next;
    logic [BAUD_W-1:0]    baud_reg,   baud_next;
    logic [BIT_W-1:0]     bit_reg,    bit_next;
    logic [DATA_BITS-1:0] shift_reg,  shift_next;
    logic                 parity_reg, parity_next;
    logic                 out_reg,    out_next;
    logic                 ready_reg,  ready_next;
    logic                 done_reg,   done_next;
    logic                 baud_last;

    assign bus.tx_out   = out_reg;
    assign bus.tx_ready = ready_reg;
    assign bus.tx_busy  = ~ready_reg;
    assign bus.tx_done  = done_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            out_reg    <= 1'b1;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            out_reg    <= out_next;
            ready_reg  <= ready_next;
            done_reg   <= done_next;
        end
    end

    // Baud counter wraps on the last cycle of a bit, which is also where every state change happens.
    always_comb begin
        state_next  = state_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        out_next    = out_reg;
        ready_next  = ready_reg;
        done_next   = 1'b0;
        baud_last   = (baud_reg == BAUD_LAST);
        baud_next   = baud_last ? '0 : baud_reg + BAUD_W'(1);

        unique case (state_reg)
            IDLE: begin
                baud_next  = '0;
                out_next   = 1'b1;
                ready_next = 1'b1;
                if (bus.tx_valid && ready_reg) begin
                    shift_next  = bus.tx_data;
                    parity_next = (PARITY_ODD != 0) ? ~^bus.tx_data : ^bus.tx_data;
                    state_next  = START;
                    ready_next  = 1'b0;
                    out_next    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_next = DATA;
                    bit_next   = '0;
                    out_next   = shift_reg[0];
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_reg == DATA_LAST) begin
                        bit_next = '0;
                        if (PARITY_EN != 0) begin
                            state_next = PARITY;
                            out_next   = parity_reg;
                        end else begin
                            state_next = STOP;
                            out_next   = 1'b1;
                        end
                    end else begin
                        bit_next   = bit_reg + BIT_W'(1);
                        shift_next = shift_reg >> 1;
                        out_next   = shift_reg[1];
                    end
                end
            end
            PARITY: begin
                if (baud_last) begin
                    state_next = STOP;
                    bit_next   = '0;
                    out_next   = 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (bit_reg == STOP_LAST) begin
                        state_next = IDLE;
                        ready_next = 1'b1;
                        done_next  = 1'b1;
                        out_next   = 1'b1;
                    end else begin
                        bit_next = bit_reg + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                out_next   = 1'b1;
                ready_next = 1'b1;
            end
        endcase
    end
endmodule
